id_ex_stage_reg: RTL and testbench
==================================

# id_ex_stage_reg

ID/EX pipeline register of the 32-bit 5-stage MIPS pipeline. It captures the decode-stage control bundle, which has already been gated by the flush logic, together with the decode data fields, and presents them to the EX stage one cycle later. It supports hold (stall), bubble insertion (flush) and a valid bit. A saturating bubble counter is included for pipeline-efficiency measurement.

## Interface
Parameters:
- DW, 32, datapath width (PC+4, register read data, sign-extended immediate)
- RW, 5, register-index width
- CW, 16, bubble-counter width

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  hold all stage contents this cycle
- flush  in  1  insert a bubble into EX this cycle
- cnt_clr  in  1  synchronous clear of bubble counter
- id_valid  in  1  ID stage holds a real instruction
- id_regdst, id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch, id_jrcontrol  in  1 each  decode control bits
- id_aluop  in  2  ALU operation class
- id_pc4, id_rd1, id_rd2, id_imm  in  DW each  PC+4, read data 1/2, sign-extended immediate
- id_rs, id_rt, id_rd  in  RW each  register indices
- ex_* (one per id_* above, same width)  out  registered copies
- ex_valid  out  1  EX holds a real instruction
- bubble_cnt  out  CW  bubbles inserted since reset/clear

## Operation
- The update decision is made per rising edge, in priority order: reset, flush, stall, load.
- Reset (reset_n=0, asynchronous): every output goes to 0, including ex_valid and bubble_cnt. Outputs stay 0 while reset_n is low.
- Flush: all ex_ control bits and ex_aluop become 0, and ex_valid becomes 0. Data and index fields load from id_* normally.
- Flush is honoured even when stall=1. When both are asserted, the bubble wins.
- Stall (flush=0): every ex_* output and ex_valid hold their previous values.
- Load (flush=0, stall=0): every ex_* output takes its id_* value, and ex_valid takes id_valid.
- Bubble counter behaviour:
  - When cnt_clr=1, the counter goes to 0. Clear takes priority over increment.
  - Otherwise the counter increments on each edge where flush=1.
  - It saturates at 2^CW−1 and never wraps.
- Control bits are never recombined or decoded here; they are pure storage.

## Timing
- Latency: 1 cycle from an id_* value to the matching ex_* value.
- There is no combinational path from any input to any output.
- If flush or stall is sampled at edge N, the effect is visible after edge N.
- Reset release: the first load occurs on the first rising edge after reset_n rises, if stall=0 and flush=0.
- Reset asserted mid-stall or mid-flush clears everything immediately. No held state survives reset.
- Back-to-back flushes produce consecutive bubbles. bubble_cnt increments by 1 each cycle.
- A stall held for any number of cycles preserves contents exactly. bubble_cnt is unchanged during a stall without flush.

## Structure
- Shared package pipe_pkg holds:
  - typedef ctrl_t: a packed struct of regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, jrcontrol and aluop[1:0] (10 bits)
  - constant CTRL_NOP = all zeros
  - the aluop encodings shared with ALU control
- The stage register stores the control bundle as one ctrl_t; a bubble loads CTRL_NOP.
- One sub-module, sat_counter (parameter width; ports clk, reset_n, clr, inc, count), implements bubble_cnt.

## Test plan
- Reset: drive reset_n=0 mid-cycle with nonzero outputs held. All outputs must be 0 before the next edge, and remain 0 until reset_n=1.
- Load: id_regwrite=1, id_aluop=2'b10, id_rd1=32'h1234_5678, id_rt=5'd9, id_valid=1, stall=0, flush=0. One edge later ex_regwrite=1, ex_aluop=2'b10, ex_rd1=32'h1234_5678, ex_rt=9 and ex_valid=1.
- Stall: load the values above, then hold stall=1 for 3 edges while id_* change to 32'hFFFF_FFFF and id_aluop=0. The ex_* outputs must still show the first values, and bubble_cnt must stay 0.
- Flush with stall: drive stall=1, flush=1 and id_memwrite=1. After the edge, ex_memwrite=0, ex_valid=0, all control bits are 0, and bubble_cnt=1.
- Counter: with CW=4, assert flush for 20 consecutive edges. bubble_cnt must read 15 and hold there. Then cnt_clr=1 together with flush=1 for one edge must give bubble_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: decode control bundle and ALU operation classes.
package pipe_pkg;

   localparam int unsigned CTRL_W = 10;

   // aluop classes understood by ALU control
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_IMM   = 2'b11;

   typedef struct packed {
      logic       regdst;
      logic       alusrc;
      logic       memtoreg;
      logic       regwrite;
      logic       memread;
      logic       memwrite;
      logic       branch;
      logic       jrcontrol;
      logic [1:0] aluop;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = ctrl_t'(CTRL_W'(0));

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ID/EX boundary bundle: decode-side inputs, EX-side registered outputs and stage controls.
interface id_ex_stage_reg_if #(
   parameter int unsigned DW = 32,
   parameter int unsigned RW = 5,
   parameter int unsigned CW = 16
);
   logic          stall;
   logic          flush;
   logic          cnt_clr;

   logic          id_valid;
   logic          id_regdst, id_alusrc, id_memtoreg, id_regwrite;
   logic          id_memread, id_memwrite, id_branch, id_jrcontrol;
   logic [1:0]    id_aluop;
   logic [DW-1:0] id_pc4, id_rd1, id_rd2, id_imm;
   logic [RW-1:0] id_rs, id_rt, id_rd;

   logic          ex_valid;
   logic          ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite;
   logic          ex_memread, ex_memwrite, ex_branch, ex_jrcontrol;
   logic [1:0]    ex_aluop;
   logic [DW-1:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
   logic [RW-1:0] ex_rs, ex_rt, ex_rd;
   logic [CW-1:0] bubble_cnt;

   modport master (
      output stall, flush, cnt_clr, id_valid,
             id_regdst, id_alusrc, id_memtoreg, id_regwrite,
             id_memread, id_memwrite, id_branch, id_jrcontrol, id_aluop,
             id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd,
      input  ex_valid,
             ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite,
             ex_memread, ex_memwrite, ex_branch, ex_jrcontrol, ex_aluop,
             ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, bubble_cnt
   );

   modport slave (
      input  stall, flush, cnt_clr, id_valid,
             id_regdst, id_alusrc, id_memtoreg, id_regwrite,
             id_memread, id_memwrite, id_branch, id_jrcontrol, id_aluop,
             id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd,
      output ex_valid,
             ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite,
             ex_memread, ex_memwrite, ex_branch, ex_jrcontrol, ex_aluop,
             ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, bubble_cnt
   );
endinterface

// File: rtl/id_ex_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);
   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr)
         count_d = '0;
      else if (inc && (count_q != {WIDTH{1'b1}}))
         count_d = count_q + WIDTH'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) count_q <= '0;
      else          count_q <= count_d;
   end

   assign count = count_q;
endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with hold, bubble insertion, valid tracking and a bubble counter.
module id_ex_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned DW = 32,
   parameter int unsigned RW = 5,
   parameter int unsigned CW = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   id_ex_stage_reg_if.slave   stage
);

   typedef struct packed {
      logic [DW-1:0] pc4;
      logic [DW-1:0] rd1;
      logic [DW-1:0] rd2;
      logic [DW-1:0] imm;
      logic [RW-1:0] rs;
      logic [RW-1:0] rt;
      logic [RW-1:0] rd;
   } data_t;

   ctrl_t id_ctrl, ctrl_q, ctrl_d;
   data_t id_data, data_q, data_d;
   logic  valid_q, valid_d;

   always_comb begin
      id_ctrl.regdst    = stage.id_regdst;
      id_ctrl.alusrc    = stage.id_alusrc;
      id_ctrl.memtoreg  = stage.id_memtoreg;
      id_ctrl.regwrite  = stage.id_regwrite;
      id_ctrl.memread   = stage.id_memread;
      id_ctrl.memwrite  = stage.id_memwrite;
      id_ctrl.branch    = stage.id_branch;
      id_ctrl.jrcontrol = stage.id_jrcontrol;
      id_ctrl.aluop     = stage.id_aluop;
      id_data.pc4       = stage.id_pc4;
      id_data.rd1       = stage.id_rd1;
      id_data.rd2       = stage.id_rd2;
      id_data.imm       = stage.id_imm;
      id_data.rs        = stage.id_rs;
      id_data.rt        = stage.id_rt;
      id_data.rd        = stage.id_rd;
   end

   // A bubble overrides stall: controls clear, data still flows so EX sees defined operands
   always_comb begin
      ctrl_d  = ctrl_q;
      data_d  = data_q;
      valid_d = valid_q;
      if (stage.flush) begin
         ctrl_d  = CTRL_NOP;
         data_d  = id_data;
         valid_d = 1'b0;
      end else if (!stage.stall) begin
         ctrl_d  = id_ctrl;
         data_d  = id_data;
         valid_d = stage.id_valid;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_q  <= CTRL_NOP;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   sat_counter #(.WIDTH(CW)) u_bubble_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (stage.cnt_clr),
      .inc     (stage.flush),
      .count   (stage.bubble_cnt)
   );

   assign stage.ex_valid     = valid_q;
   assign stage.ex_regdst    = ctrl_q.regdst;
   assign stage.ex_alusrc    = ctrl_q.alusrc;
   assign stage.ex_memtoreg  = ctrl_q.memtoreg;
   assign stage.ex_regwrite  = ctrl_q.regwrite;
   assign stage.ex_memread   = ctrl_q.memread;
   assign stage.ex_memwrite  = ctrl_q.memwrite;
   assign stage.ex_branch    = ctrl_q.branch;
   assign stage.ex_jrcontrol = ctrl_q.jrcontrol;
   assign stage.ex_aluop     = ctrl_q.aluop;
   assign stage.ex_pc4       = data_q.pc4;
   assign stage.ex_rd1       = data_q.rd1;
   assign stage.ex_rd2       = data_q.rd2;
   assign stage.ex_imm       = data_q.imm;
   assign stage.ex_rs        = data_q.rs;
   assign stage.ex_rt        = data_q.rt;
   assign stage.ex_rd        = data_q.rd;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg with a 4-bit bubble counter.
module tb_id_ex_stage_reg;
   localparam int unsigned DW = 32;
   localparam int unsigned RW = 5;
   localparam int unsigned CW = 4;

   logic clk = 1'b0;
   logic reset_n;
   int   errors = 0;
   int   checks = 0;

   id_ex_stage_reg_if #(.DW(DW), .RW(RW), .CW(CW)) bus ();

   id_ex_stage_reg #(.DW(DW), .RW(RW), .CW(CW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .stage   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ctrl_bits();
      return 32'({bus.ex_regdst, bus.ex_alusrc, bus.ex_memtoreg, bus.ex_regwrite,
                  bus.ex_memread, bus.ex_memwrite, bus.ex_branch, bus.ex_jrcontrol,
                  bus.ex_aluop});
   endfunction

   function automatic logic [31:0] any_out();
      return 32'(|{ctrl_bits(), bus.ex_valid, bus.ex_pc4, bus.ex_rd1, bus.ex_rd2,
                   bus.ex_imm, bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.bubble_cnt});
   endfunction

   initial begin
      reset_n = 1'b0;
      bus.stall = 0; bus.flush = 0; bus.cnt_clr = 0; bus.id_valid = 0;
      bus.id_regdst = 0; bus.id_alusrc = 0; bus.id_memtoreg = 0; bus.id_regwrite = 0;
      bus.id_memread = 0; bus.id_memwrite = 0; bus.id_branch = 0; bus.id_jrcontrol = 0;
      bus.id_aluop = 2'b00;
      bus.id_pc4 = '0; bus.id_rd1 = '0; bus.id_rd2 = '0; bus.id_imm = '0;
      bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;

      step(); step();
      chk("reset_all_zero", any_out(), 32'd0);
      @(negedge clk); reset_n = 1'b1;

      // plain load
      bus.id_regwrite = 1; bus.id_aluop = 2'b10; bus.id_rd1 = 32'h1234_5678;
      bus.id_rt = 5'd9; bus.id_valid = 1; bus.id_pc4 = 32'h0000_0044; bus.id_rd = 5'd3;
      step();
      chk("load_regwrite", 32'(bus.ex_regwrite), 32'd1);
      chk("load_aluop",    32'(bus.ex_aluop),    32'd2);
      chk("load_rd1",      bus.ex_rd1,           32'h1234_5678);
      chk("load_rt",       32'(bus.ex_rt),       32'd9);
      chk("load_valid",    32'(bus.ex_valid),    32'd1);
      chk("load_pc4",      bus.ex_pc4,           32'h44);

      // stall for 3 edges while inputs change
      bus.stall = 1; bus.id_rd1 = 32'hFFFF_FFFF; bus.id_aluop = 2'b00;
      bus.id_regwrite = 0; bus.id_rt = 5'd31; bus.id_valid = 0; bus.id_pc4 = 32'hFFFF_FFFF;
      repeat (3) step();
      chk("stall_rd1",      bus.ex_rd1,           32'h1234_5678);
      chk("stall_aluop",    32'(bus.ex_aluop),    32'd2);
      chk("stall_regwrite", 32'(bus.ex_regwrite), 32'd1);
      chk("stall_rt",       32'(bus.ex_rt),       32'd9);
      chk("stall_valid",    32'(bus.ex_valid),    32'd1);
      chk("stall_bubbles",  32'(bus.bubble_cnt),  32'd0);

      // flush wins over stall; data fields still load
      bus.flush = 1; bus.id_memwrite = 1; bus.id_regwrite = 1; bus.id_valid = 1;
      bus.id_rd1 = 32'hAAAA_5555;
      step();
      chk("flush_memwrite", 32'(bus.ex_memwrite), 32'd0);
      chk("flush_ctrl",     ctrl_bits(),          32'd0);
      chk("flush_valid",    32'(bus.ex_valid),    32'd0);
      chk("flush_bubbles",  32'(bus.bubble_cnt),  32'd1);
      chk("flush_rd1",      bus.ex_rd1,           32'hAAAA_5555);

      // load nonzero state, then reset mid-cycle
      bus.flush = 0; bus.stall = 0;
      step();
      chk("preload_memwrite", 32'(bus.ex_memwrite), 32'd1);
      #2 reset_n = 1'b0;
      #1 chk("async_reset_zero", any_out(), 32'd0);
      bus.stall = 1; bus.flush = 1;
      step();
      chk("reset_hold_zero", any_out(), 32'd0);
      bus.stall = 0; bus.flush = 0;
      @(negedge clk); reset_n = 1'b1;
      step();
      chk("first_load_valid", 32'(bus.ex_valid),    32'd1);
      chk("first_load_rd1",   bus.ex_rd1,           32'hAAAA_5555);

      // back-to-back bubbles, then saturation
      bus.flush = 1;
      step();
      chk("b2b_cnt1", 32'(bus.bubble_cnt), 32'd1);
      step();
      chk("b2b_cnt2", 32'(bus.bubble_cnt), 32'd2);
      repeat (18) step();
      chk("sat_cnt15", 32'(bus.bubble_cnt), 32'd15);
      step();
      chk("sat_hold", 32'(bus.bubble_cnt), 32'd15);

      // clear beats increment
      bus.cnt_clr = 1;
      step();
      chk("clr_over_inc", 32'(bus.bubble_cnt), 32'd0);
      bus.cnt_clr = 0;
      step();
      chk("post_clr_inc", 32'(bus.bubble_cnt), 32'd1);

      // stall without flush leaves the counter alone
      bus.flush = 0; bus.stall = 1;
      repeat (2) step();
      chk("stall_cnt_hold", 32'(bus.bubble_cnt), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
